wb_regfile: RTL and testbench

- Receiving end of the writeback interface: it consumes the selected writeback word and commits it to the architectural register file.
- Provides two combinational read ports for the decode stage, with same-cycle write-to-read bypass.
- Holds a per-register pending scoreboard, set at issue and cleared at writeback, that generates a decode stall.
- Sits between the writeback stage and the decode/issue stage of the 5-stage pipeline.

---
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-side architectural register file: one commit port, two bypassed
// combinational read ports, and a per-register pending scoreboard for decode stalls.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWrite,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  input  logic                   issue_valid,
  input  logic                   issue_wr,
  input  logic [ADDR_W-1:0]      issue_dest,
  output logic                   stall,
  output logic [(2**ADDR_W)-1:0] pending
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  logic              w_wb_en;
  logic              w_iss_en;
  logic              w_rs_byp;
  logic              w_rt_byp;

  // Writeback is masked during reset so the read ports and stall read 0 throughout.
  assign w_wb_en  = RegWrite && rst && (wb_addr != '0);
  assign w_iss_en = issue_valid && issue_wr && (issue_dest != '0);
  assign w_rs_byp = w_wb_en && (wb_addr == rs_addr);
  assign w_rt_byp = w_wb_en && (wb_addr == rt_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Clear first, then set: a newer issuing producer keeps ownership of the register.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_en) begin
      w_pending_nxt[wb_addr] = 1'b0;
    end
    if (w_iss_en) begin
      w_pending_nxt[issue_dest] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = w_rs_byp ? wb_data : r_regs[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = w_rt_byp ? wb_data : r_regs[rt_addr];
    end
  end

  // A same-cycle writeback resolves the hazard through the bypass.
  assign stall   = (r_pending[rs_addr] && !w_rs_byp) || (r_pending[rt_addr] && !w_rt_byp);
  assign pending = r_pending;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, mid-cycle reset
// sequence, and randomized traffic against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic        issue_wr;
  logic [4:0]  issue_dest;
  logic        stall;
  logic [31:0] pending;

  int checks   = 0;
  int failures = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        iv;
    logic        iw;
    logic [4:0]  id;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_stall;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic iv, input logic iw, input logic [4:0] id,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic es, input logic [31:0] ep);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.iv = iv; v.iw = iw; v.id = id;
    v.exp_a = ea; v.exp_b = eb; v.exp_stall = es; v.exp_pend = ep;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic iv, input logic iw, input logic [4:0] id);
    RegWrite = we; wb_addr = wa; wb_data = wd; rs_addr = ra; rt_addr = rb;
    issue_valid = iv; issue_wr = iw; issue_dest = id;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p4, p9;
    p4 = 32'h1 << 4;
    p9 = 32'h1 << 9;
    //      we wa  wd            ra  rb  iv iw id  exp_a    exp_b    st exp_pend
    vecs.push_back(mk(1, 0,  32'hFFFF_FFFF, 0,  5,  0, 0, 0,  0,       0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             0,  0,  0, 0, 0,  0,       0,       0, 0));
    vecs.push_back(mk(1, 3,  32'd255,       0,  0,  0, 0, 0,  0,       0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             3,  0,  0, 0, 0,  255,     0,       0, 0));
    vecs.push_back(mk(1, 31, 32'd0,         3,  31, 0, 0, 0,  255,     0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             31, 3,  0, 0, 0,  0,       255,     0, 0));
    vecs.push_back(mk(1, 7,  32'd10,        0,  0,  0, 0, 0,  0,       0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             7,  0,  0, 0, 0,  10,      0,       0, 0));
    vecs.push_back(mk(1, 7,  32'd99,        7,  7,  0, 0, 0,  99,      99,      0, 0));
    vecs.push_back(mk(0, 0,  0,             7,  7,  0, 0, 0,  99,      99,      0, 0));
    vecs.push_back(mk(0, 0,  0,             4,  0,  1, 1, 4,  0,       0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             4,  0,  0, 0, 0,  0,       0,       1, p4));
    vecs.push_back(mk(1, 4,  32'h1234,      4,  4,  0, 0, 0,  32'h1234, 32'h1234, 0, p4));
    vecs.push_back(mk(0, 0,  0,             4,  0,  0, 0, 0,  32'h1234, 0,       0, 0));
    vecs.push_back(mk(0, 0,  0,             0,  0,  1, 1, 9,  0,       0,       0, 0));
    vecs.push_back(mk(1, 9,  32'd42,        9,  0,  1, 1, 9,  42,      0,       0, p9));
    vecs.push_back(mk(0, 0,  0,             9,  9,  0, 0, 0,  42,      42,      1, p9));
    vecs.push_back(mk(0, 0,  0,             5,  0,  1, 0, 5,  0,       0,       0, p9));
    vecs.push_back(mk(0, 0,  0,             5,  9,  1, 1, 0,  0,       42,      1, p9));
    vecs.push_back(mk(0, 0,  0,             0,  0,  0, 0, 0,  0,       0,       0, p9));

    // Reset held: even a live writeback must not leak through the bypass.
    rst = 1'b0;
    drive(0, 0, 0, 0, 5, 0, 0, 0);
    #2;
    drive(1, 5, 32'hDEAD_BEEF, 0, 5, 1, 1, 5);
    #1;
    chk("reset_rs", 64'(rs_data), 64'd0);
    chk("reset_rt_nobypass", 64'(rt_data), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    #10;
    chk("reset_pending", 64'(pending), 64'd0);
    drive(0, 0, 0, 0, 5, 0, 0, 0);
    #8;
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb,
            vecs[i].iv, vecs[i].iw, vecs[i].id);
      #1;
      chk($sformatf("vec%0d_rs", i), 64'(rs_data), 64'(vecs[i].exp_a));
      chk($sformatf("vec%0d_rt", i), 64'(rt_data), 64'(vecs[i].exp_b));
      chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_pend", i), 64'(pending), 64'(vecs[i].exp_pend));
      step();
    end

    // Asynchronous reset between edges with live pending and register state.
    drive(1, 2, 32'd77, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1, 2);
    step();
    drive(0, 0, 0, 2, 0, 0, 0, 0);
    #1;
    chk("midrst_pre_rs", 64'(rs_data), 64'd77);
    chk("midrst_pre_stall", 64'(stall), 64'd1);
    chk("midrst_pre_pend", 64'(pending), 64'(32'h1 << 2) | 64'(p9));
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rs", 64'(rs_data), 64'd0);
    chk("midrst_pend", 64'(pending), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    #1;
    rst = 1'b1;
    step();
    #1;
    chk("postrst_rs", 64'(rs_data), 64'd0);
    chk("postrst_pend", 64'(pending), 64'd0);

    // Randomized traffic against the reference model (state is all zero after reset).
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic        we, iv, iw, es;
      logic [4:0]  wa, ra, rb, id;
      logic [31:0] wd, ea, eb, ep;
      we = 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 1));
      iw = 1'($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      id = 5'($urandom_range(0, 7));
      if (n % 7 == 0) begin
        wa = 5'($urandom);
        ra = 5'($urandom);
        id = 5'($urandom);
      end
      wd = $urandom;
      step();
      drive(we, wa, wd, ra, rb, iv, iw, id);
      #1;
      ea = (ra == 0) ? 32'd0 : (we && wa == ra) ? wd : m_regs[ra];
      eb = (rb == 0) ? 32'd0 : (we && wa == rb) ? wd : m_regs[rb];
      es = (m_pend[ra] && !(we && wa == ra)) || (m_pend[rb] && !(we && wa == rb));
      ep = '0;
      for (int k = 0; k < 32; k++) ep[k] = m_pend[k];
      chk("rand_rs", 64'(rs_data), 64'(ea));
      chk("rand_rt", 64'(rt_data), 64'(eb));
      chk("rand_stall", 64'(stall), 64'(es));
      chk("rand_pend", 64'(pending), 64'(ep));
      @(posedge clk);
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (iv && iw && id != 0) m_pend[id] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
